// File: rtl/zx_bus_pkg.sv
// Shared constants and bus-cycle decode for the zx48 CPU bus responder.
package zx_bus_pkg;

    localparam int unsigned TPF_DEF  = 69888;
    localparam int unsigned INTW_DEF = 32;
    localparam int unsigned CW_DEF   = 17;

    localparam int unsigned KBD_ROWS = 8;
    localparam int unsigned KBD_COLS = 5;
    localparam int unsigned KBD_W    = KBD_ROWS * KBD_COLS;

    localparam logic [15:0] PORT_ULA_MASK = 16'h0001;
    localparam logic [1:0]  ROM_PAGE      = 2'b00;
    localparam logic [7:0]  FLOAT_BUS     = 8'hFF;

    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        logic io_ula;
        logic int_ack;
    } cycle_t;

    // Classify the current bus cycle from the raw active-low strobes.
    function automatic cycle_t decode_cycle(
        input logic        rfsh,
        input logic        mreq,
        input logic        iorq,
        input logic        m1,
        input logic        rd,
        input logic        wr,
        input logic [15:0] a
    );
        cycle_t c;
        c.mem_rd  = !mreq && !rd && rfsh;
        c.mem_wr  = !mreq && !wr;
        c.io_ula  = !iorq && m1 && ((a & PORT_ULA_MASK) == 16'h0000);
        c.int_ack = !iorq && !m1;
        return c;
    endfunction

endpackage

// File: rtl/zx_kbd_scan.sv
// Keyboard matrix scan: AND of every half-row whose select line is low.
module zx_kbd_scan
    import zx_bus_pkg::*;
(
    input  logic [KBD_ROWS-1:0] sel,
    input  logic [KBD_W-1:0]    kbd,
    output logic [KBD_COLS-1:0] keys
);

    always_comb begin
        keys = '1;
        for (int r = 0; r < int'(KBD_ROWS); r++) begin
            if (!sel[r]) begin
                keys = keys & kbd[r*KBD_COLS +: KBD_COLS];
            end
        end
    end

endmodule

// File: rtl/zx_bus_responder.sv
// Z80 bus slave for the zx48 core: ULA port 0xFE, read-data mux,
// ROM-protected memory write strobe and the 50 Hz frame interrupt.
module zx_bus_responder
    import zx_bus_pkg::*;
#(
    parameter int unsigned TPF  = TPF_DEF,
    parameter int unsigned INTW = INTW_DEF,
    parameter int unsigned CW   = CW_DEF
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              ce,
    input  logic              rfsh,
    input  logic              mreq,
    input  logic              iorq,
    input  logic              m1,
    input  logic              rd,
    input  logic              wr,
    input  logic [15:0]       a,
    input  logic [7:0]        d,
    input  logic [7:0]        md,
    input  logic [KBD_W-1:0]  kbd,
    input  logic              ear,
    output logic [7:0]        q,
    output logic              mi,
    output logic              we,
    output logic [2:0]        border,
    output logic              mic,
    output logic              speaker
);

    cycle_t              cyc;
    logic [KBD_COLS-1:0] keys;
    logic [CW-1:0]       count;
    logic                wr_q;
    logic                wr_fall;

    assign cyc     = decode_cycle(rfsh, mreq, iorq, m1, rd, wr, a);
    assign wr_fall = wr_q && !wr;

    zx_kbd_scan u_kbd_scan (
        .sel  (a[15:8]),
        .kbd  (kbd),
        .keys (keys)
    );

    // Edge detection runs every clock; only the frame counter follows ce.
    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            mi      <= 1'b1;
            wr_q    <= 1'b1;
            we      <= 1'b0;
            border  <= 3'd0;
            mic     <= 1'b0;
            speaker <= 1'b0;
        end else begin
            wr_q <= wr;
            we   <= wr_fall && cyc.mem_wr && (a[15:14] != ROM_PAGE);
            if (wr_fall && cyc.io_ula) begin
                border  <= d[2:0];
                mic     <= d[3];
                speaker <= d[4];
            end
            mi <= !(count < CW'(INTW));
            if (ce) begin
                count <= (count == CW'(TPF - 1)) ? '0 : count + CW'(1);
            end
        end
    end

    // Read-data mux; interrupt acknowledge wins even over a stray mreq.
    always_comb begin
        q = FLOAT_BUS;
        if (cyc.int_ack) begin
            q = FLOAT_BUS;
        end else if (cyc.mem_rd) begin
            q = md;
        end else if (cyc.io_ula && !rd) begin
            q = {1'b1, ear, 1'b1, keys};
        end
    end

endmodule

// File: tb/tb_zx_bus_responder.sv
// Self-checking bench for zx_bus_responder: directed scenarios plus random bus
// traffic compared every clock against a behavioural model.
module tb_zx_bus_responder;

    localparam int unsigned TPF_T  = 1200;
    localparam int unsigned INTW_T = 32;
    localparam int unsigned CW_T   = 11;

    logic        clock;
    logic        reset;
    logic        ce;
    logic        rfsh;
    logic        mreq;
    logic        iorq;
    logic        m1;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  md;
    logic [39:0] kbd;
    logic        ear;
    logic [7:0]  q;
    logic        mi;
    logic        we;
    logic [2:0]  border;
    logic        mic;
    logic        speaker;

    zx_bus_responder #(
        .TPF  (TPF_T),
        .INTW (INTW_T),
        .CW   (CW_T)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ce      (ce),
        .rfsh    (rfsh),
        .mreq    (mreq),
        .iorq    (iorq),
        .m1      (m1),
        .rd      (rd),
        .wr      (wr),
        .a       (a),
        .d       (d),
        .md      (md),
        .kbd     (kbd),
        .ear     (ear),
        .q       (q),
        .mi      (mi),
        .we      (we),
        .border  (border),
        .mic     (mic),
        .speaker (speaker)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the responder should hold after each clock.
    int         m_count;
    logic       m_mi;
    logic       m_wr_prev;
    logic       m_we;
    logic [2:0] m_border;
    logic       m_mic;
    logic       m_spk;
    int         we_seen;
    int         mi_low_seen;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] expected_q();
        logic [4:0] keys;
        keys = 5'h1F;
        for (int r = 0; r < 8; r++) begin
            if (a[8+r] == 1'b0) keys = keys & kbd[5*r +: 5];
        end
        if (!iorq && !m1)             return 8'hFF;
        if (!mreq && !rd && rfsh)     return md;
        if (!iorq && m1 && !a[0] && !rd) return {1'b1, ear, 1'b1, keys};
        return 8'hFF;
    endfunction

    // One clock: advance the model on the inputs seen at the edge, then compare.
    task automatic step();
        logic fall;
        @(posedge clock);
        if (reset) begin
            m_count = 0; m_mi = 1'b1; m_wr_prev = 1'b1; m_we = 1'b0;
            m_border = 3'd0; m_mic = 1'b0; m_spk = 1'b0;
        end else begin
            fall = m_wr_prev && !wr;
            m_we = fall && !mreq && (a[15:14] != 2'b00);
            if (fall && !iorq && m1 && !a[0]) begin
                m_border = d[2:0]; m_mic = d[3]; m_spk = d[4];
            end
            m_wr_prev = wr;
            m_mi = (m_count >= int'(INTW_T)) ? 1'b1 : 1'b0;
            if (ce) m_count = (m_count + 1) % int'(TPF_T);
        end
        #1;
        check_eq("q", 64'(q), 64'(expected_q()));
        check_eq("mi", 64'(mi), 64'(m_mi));
        check_eq("we", 64'(we), 64'(m_we));
        check_eq("border", 64'(border), 64'(m_border));
        check_eq("mic", 64'(mic), 64'(m_mic));
        check_eq("speaker", 64'(speaker), 64'(m_spk));
        if (we) we_seen++;
        if (!mi) mi_low_seen++;
    endtask

    task automatic bus_idle();
        rfsh = 1'b1; mreq = 1'b1; iorq = 1'b1; m1 = 1'b1; rd = 1'b1; wr = 1'b1;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; bus_idle();
        a = 16'h0000; d = 8'h00; md = 8'h00; kbd = '1; ear = 1'b1;
        m_count = 0; m_mi = 1'b1; m_wr_prev = 1'b1; m_we = 1'b0;
        m_border = 3'd0; m_mic = 1'b0; m_spk = 1'b0;
        we_seen = 0; mi_low_seen = 0;

        // Reset and first interrupt window with ce every 4th clock.
        repeat (3) step();
        check_eq("reset_mi", 64'(mi), 64'd1);
        check_eq("reset_border", 64'(border), 64'd0);
        reset = 1'b0;
        step();
        check_eq("int_first_window", 64'(mi), 64'd0);
        for (int i = 0; i < 160; i++) begin
            ce = (i % 4 == 3);
            step();
        end
        check_eq("int_after_window", 64'(mi), 64'd1);

        // Continuous ce through a frame wrap: exactly one 32-clock window.
        ce = 1'b1;
        mi_low_seen = 0;
        for (int i = 0; i < int'(TPF_T) + 40; i++) step();
        check_eq("int_wrap_width", 64'(mi_low_seen), 64'd32);
        ce = 1'b0;

        // Port 0xFE write held low for 6 clocks, then a non-ULA write.
        a = 16'h00FE; d = 8'h1D; iorq = 1'b0; wr = 1'b0;
        repeat (6) step();
        bus_idle(); step();
        check_eq("ula_border", 64'(border), 64'd5);
        check_eq("ula_mic", 64'(mic), 64'd1);
        check_eq("ula_speaker", 64'(speaker), 64'd1);
        a = 16'h00FF; d = 8'h02; iorq = 1'b0; wr = 1'b0;
        repeat (3) step();
        bus_idle(); step();
        check_eq("odd_port_ignored", 64'(border), 64'd5);

        // Keyboard reads.
        kbd = '1; kbd[2] = 1'b0; ear = 1'b0;
        a = 16'hFEFE; iorq = 1'b0; rd = 1'b0;
        #1 check_eq("kbd_row0", 64'(q), 64'hBB);
        step();
        a = 16'h7FFE;
        #1 check_eq("kbd_row7", 64'(q), 64'hBF);
        step();
        bus_idle(); step();

        // Memory writes: RAM gets one strobe, ROM none.
        we_seen = 0;
        a = 16'h4000; d = 8'h55; mreq = 1'b0; wr = 1'b0;
        repeat (4) step();
        bus_idle(); step();
        check_eq("we_ram_once", 64'(we_seen), 64'd1);
        we_seen = 0;
        a = 16'h1234; mreq = 1'b0; wr = 1'b0;
        repeat (4) step();
        bus_idle(); step();
        check_eq("we_rom_blocked", 64'(we_seen), 64'd0);

        // Interrupt acknowledge and memory read data.
        m1 = 1'b0; iorq = 1'b0;
        #1 check_eq("int_ack_q", 64'(q), 64'hFF);
        step();
        bus_idle(); md = 8'h3E; mreq = 1'b0; rd = 1'b0; a = 16'h8000;
        #1 check_eq("mem_rd_q", 64'(q), 64'h3E);
        step();
        rfsh = 1'b0;
        #1 check_eq("refresh_q", 64'(q), 64'hFF);
        step();
        bus_idle(); step();

        // Reset in the middle of a wr-low I/O cycle.
        a = 16'h00FE; d = 8'h07; iorq = 1'b0; wr = 1'b0;
        step();
        check_eq("pre_reset_border", 64'(border), 64'd7);
        reset = 1'b1;
        repeat (2) step();
        check_eq("reset_clears_border", 64'(border), 64'd0);
        bus_idle(); step();
        reset = 1'b0;
        repeat (3) step();
        check_eq("no_relatch_after_reset", 64'(border), 64'd0);
        a = 16'h00FE; d = 8'h0B; iorq = 1'b0; wr = 1'b0;
        step();
        bus_idle(); step();
        check_eq("new_edge_latches", 64'(border), 64'd3);

        // Random bus traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(199) == 0);
            ce    = 1'($urandom_range(1));
            rfsh  = ($urandom_range(7) != 0);
            mreq  = 1'($urandom_range(1));
            iorq  = 1'($urandom_range(1));
            m1    = ($urandom_range(3) != 0);
            rd    = 1'($urandom_range(1));
            wr    = 1'($urandom_range(1));
            a     = 16'($urandom);
            d     = 8'($urandom);
            md    = 8'($urandom);
            kbd   = 40'({$urandom, $urandom}) | 40'({$urandom, $urandom});
            ear   = 1'($urandom_range(1));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/zx_bus_responder.md
Name: zx_bus_responder

Overview:
- Slave side of the Z80 bus in the zx48 core: consumes the active-low strobes, address and data driven by the CPU wrapper, and returns read data and the maskable interrupt.
- Implements the ULA port 0xFE (border/MIC/speaker write, keyboard/EAR read), the interrupt-acknowledge data, memory write strobes with ROM protection, and the 50 Hz frame interrupt.
- Sits beside the CPU; feeds the CPU's `d` and `mi` inputs and drives the video/audio/memory glue.

Parameters:
- TPF, 69888, T-states per frame; interrupt period.
- INTW, 32, T-states the interrupt stays asserted.
- CW, 17, frame counter width; must satisfy 2^CW >= TPF.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  T-state clock enable; same enable as the CPU positive edge.
- rfsh  in  1  active-low refresh from CPU.
- mreq  in  1  active-low memory request.
- iorq  in  1  active-low I/O request.
- m1  in  1  active-low M1.
- rd  in  1  active-low read.
- wr  in  1  active-low write.
- a  in  16  CPU address.
- d  in  8  CPU data out (write data).
- md  in  8  memory read data from ROM/RAM glue.
- kbd  in  40  keyboard matrix, active-low: row r = kbd[5r+4:5r], r = 0..7.
- ear  in  1  tape input.
- q  out  8  data to CPU.
- mi  out  1  active-low maskable interrupt.
- we  out  1  one-clock memory write strobe.
- border  out  3  border colour.
- mic  out  1  MIC output.
- speaker  out  1  beeper output.

Behaviour:
- Reset (synchronous, active-high): border=0, mic=0, speaker=0, we=0, mi=1, frame counter=0, strobe history registers=1 (inactive).
- Reset overrides everything: a cycle in progress is discarded, and no write or strobe is emitted on the clock reset is high.
- Frame counter:
  - Increments on each clock with ce=1; wraps TPF-1 -> 0.
  - mi=0 while count < INTW (registered from count), otherwise 1.
  - After reset, the first INT window starts immediately: count 0..31 gives mi=0.
- Cycle decode (combinational from current inputs):
  - memRd = !mreq & !rd & rfsh.
  - memWr = !mreq & !wr.
  - ioUla = !iorq & m1 & !a[0].
  - intAck = !iorq & !m1.
- q mux, combinational, in priority order:
  - intAck -> 8'hFF.
  - memRd -> md.
  - ioUla & !rd -> {1, ear, 1, keys[4:0]}, where keys = bitwise AND of every row r with a[8+r]=0. If no row is selected, keys=5'h1F.
  - all else -> 8'hFF (floating bus).
- Port 0xFE write:
  - Detect the falling edge of wr: registered wr=1 and current wr=0, while ioUla is true.
  - On that clock: border<=d[2:0], mic<=d[3], speaker<=d[4].
  - Exactly one latch per I/O cycle; holding wr low causes no re-latch.
- Memory write strobe:
  - we=1 for exactly one clock on the falling edge of wr while memWr is true and a[15:14]!=2'b00.
  - Writes to 0x0000-0x3FFF give we=0 (ROM protected).
- Edge detection runs on every clock, not gated by ce; wr history is sampled every clock.
- Simultaneous events:
  - An INT window start coinciding with an I/O write: both occur, independent.
  - intAck and mreq low together cannot occur on a legal Z80; intAck still wins the q mux.
- An I/O write with a[0]=1 is ignored (not ULA).
- Latency: outputs q and mi are valid the same clock as the inputs (q) or registered by one clock (mi).

Decomposition:
- Package zx_bus_pkg:
  - PORT_ULA_MASK (a[0]).
  - ROM_PAGE (2'b00).
  - FLOAT_BUS (8'hFF).
  - Default TPF and INTW localparams shared with the video timing block.
- Sub-module zx_kbd_scan: combinational 40-bit matrix AND by a[15:8] -> keys[4:0]. This is the one natural split; everything else stays flat.

Test Plan:
- Reset held 3 clocks, then released with ce every 4th clock -> mi=0 for first 32 ce pulses, high until count wraps at 69888, low again for 32.
- IO write a=16'h00FE, d=8'h1D, wr pulse low 6 clocks -> border=5, mic=1, speaker=1 latched once; a later wr low at a=16'h00FF -> no change.
- IO read a=16'hFEFE, kbd all 1 except kbd[2]=0 (row 0, bit 2), ear=0 -> q=8'hBB; a=16'h7FFE (row 7 only) -> q=8'hBF.
- Memory write a=16'h4000 -> we high exactly one clock; a=16'h1234 -> we stays 0.
- intAck (m1=0, iorq=0) -> q=8'hFF; memRd with md=8'h3E -> q=8'h3E; memRd with rfsh=0 -> q=8'hFF.
- reset asserted during a wr-low IO cycle -> border/mic/speaker return to 0 and are not updated until a new wr falling edge.
